// File: rtl/fp_pkg.sv
`default_nettype none
// =============================================================================
// Module      : fp_pkg
// Description : Floating-point word format helpers and default format constants.
// Revision    : 1.0 - initial release
// =============================================================================
package fp_pkg;

    localparam int unsigned c_def_exp_width  = 8;
    localparam int unsigned c_def_frac_width = 23;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    localparam int unsigned c_def_fp_width = fp_width(c_def_exp_width, c_def_frac_width);

endpackage
`default_nettype wire

// File: rtl/fp_elastic_stage.sv
`default_nettype none
// =============================================================================
// Module      : fp_elastic_stage
// Description : One elastic pipeline slot: a valid flag plus an unreset data word.
// Revision    : 1.0 - initial release
// =============================================================================
module fp_elastic_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (en_i) begin
            r_valid <= valid_i;
        end
    end

    // Payload of an empty slot is never observed, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_data <= data_i;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule
`default_nettype wire

// File: rtl/fp_latency_matcher.sv
`default_nettype none
// =============================================================================
// Module      : fp_latency_matcher
// Description : Elastic LATENCY-stage delay line for packed FP words with
//               bubble collapsing, flush and occupancy count.
// Revision    : 1.0 - initial release
// =============================================================================
module fp_latency_matcher
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_WIDTH  = c_def_exp_width,
    parameter  int unsigned FRAC_WIDTH = c_def_frac_width,
    parameter  int unsigned CHANNELS   = 1,
    parameter  int unsigned LATENCY    = 2,
    localparam int unsigned FP_WIDTH   = fp_width(EXP_WIDTH, FRAC_WIDTH),
    localparam int unsigned CNT_WIDTH  = $clog2(LATENCY + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [CHANNELS*FP_WIDTH-1:0] fp_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [CHANNELS*FP_WIDTH-1:0] fp_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [CNT_WIDTH-1:0]         count_o
);

    localparam int unsigned c_data_w = CHANNELS * FP_WIDTH;

    logic [LATENCY-1:0]  w_valid;
    logic [LATENCY-1:0]  w_vin;
    logic [LATENCY-1:0]  w_en;
    logic [c_data_w-1:0] w_data [LATENCY];
    logic [c_data_w-1:0] w_din  [LATENCY];
    logic [CNT_WIDTH-1:0] w_count;

    // A slot may load when it is empty or the slot after it is moving,
    // which lets empty slots fill even while the output is stalled.
    always_comb begin
        w_en = '0;
        w_en[LATENCY-1] = !w_valid[LATENCY-1] || ready_i;
        for (int k = int'(LATENCY) - 2; k >= 0; k--) begin
            w_en[k] = !w_valid[k] || w_en[k+1];
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_vin[k] = valid_i;
            assign w_din[k] = fp_i;
        end else begin : g_body
            assign w_vin[k] = w_valid[k-1];
            assign w_din[k] = w_data[k-1];
        end

        fp_elastic_stage #(
            .WIDTH (c_data_w)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .en_i    (w_en[k]),
            .valid_i (w_vin[k]),
            .data_i  (w_din[k]),
            .valid_o (w_valid[k]),
            .data_o  (w_data[k])
        );
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < int'(LATENCY); k++) begin
            w_count = w_count + CNT_WIDTH'(w_valid[k]);
        end
    end

    assign ready_o = w_en[0];
    assign valid_o = w_valid[LATENCY-1];
    assign fp_o    = w_data[LATENCY-1];
    assign count_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_latency_matcher.sv
`default_nettype none
// =============================================================================
// Module      : tb_fp_latency_matcher
// Description : Scoreboard bench for fp_latency_matcher (2 channels, 3 stages).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fp_latency_matcher;

    localparam int unsigned c_exp  = 8;
    localparam int unsigned c_frac = 23;
    localparam int unsigned c_ch   = 2;
    localparam int unsigned c_lat  = 3;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [63:0] fp_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] fp_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  count_o;

    int n_total = 0;
    int n_bad   = 0;
    int n_out   = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    fp_latency_matcher #(
        .EXP_WIDTH  (c_exp),
        .FRAC_WIDTH (c_frac),
        .CHANNELS   (c_ch),
        .LATENCY    (c_lat)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .fp_i    (fp_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .fp_o    (fp_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .count_o (count_o)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Monitor: compare each delivered beat against the oldest accepted one.
    always @(negedge clk) begin
        logic [63:0] w_exp;
        if (valid_o && ready_i) begin
            n_out++;
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_output got=%h want=none at %0t", fp_o, $time);
            end else begin
                w_exp = sb.pop_front();
                check("sb_data", fp_o, w_exp);
            end
        end
        if (!rst_ni || flush_i) begin
            sb.delete();
        end else if (valid_i && ready_o) begin
            sb.push_back(fp_i);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_cnt [4];
        logic       exp_v   [4];
        exp_cnt = '{2'd1, 2'd1, 2'd1, 2'd0};
        exp_v   = '{1'b0, 1'b0, 1'b1, 1'b0};

        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; fp_i = '0;
        tick(); tick();
        rst_ni = 1'b1;
        samp();
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_count",   64'(count_o), 64'd0);
        check("rst_ready",   64'(ready_o), 64'd1);
        tick();

        // Single beat: appears three cycles after acceptance.
        fp_i = 64'h40000000_3F800000; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            samp();
            check("lat_count", 64'(count_o), 64'(exp_cnt[i]));
            check("lat_valid", 64'(valid_o), 64'(exp_v[i]));
            if (i == 2) check("lat_data", fp_o, 64'h40000000_3F800000);
            tick();
        end

        // Back-to-back stream.
        for (int i = 0; i < 6; i++) begin
            fp_i = 64'h41000000_C0000000 + 64'(i); valid_i = 1'b1;
            samp();
            check("stream_ready", 64'(ready_o), 64'd1);
            tick();
        end
        valid_i = 1'b0;
        repeat (5) tick();

        // Stall: only three beats fit.
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fp_i = 64'h3F000000_BF000000 + 64'(i); valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        samp();
        check("stall_count", 64'(count_o), 64'd3);
        check("stall_ready", 64'(ready_o), 64'd0);
        check("stall_valid", 64'(valid_o), 64'd1);
        check("stall_data",  fp_o, 64'h3F000000_BF000000);
        tick();
        samp();
        check("stall_hold", fp_o, 64'h3F000000_BF000000);
        tick();
        ready_i = 1'b1;
        samp(); check("drain_cnt3", 64'(count_o), 64'd3);
        tick(); samp(); check("drain_cnt2", 64'(count_o), 64'd2);
        tick(); samp(); check("drain_cnt1", 64'(count_o), 64'd1);
        tick(); samp(); check("drain_cnt0", 64'(count_o), 64'd0);
        tick();

        // Bubble collapse behind a stalled output.
        ready_i = 1'b0;
        fp_i = 64'h00000001_0000000A; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        samp();
        check("bubble_cnt1",  64'(count_o), 64'd1);
        check("bubble_ready", 64'(ready_o), 64'd1);
        tick();
        fp_i = 64'h00000002_0000000B; valid_i = 1'b1;
        tick();
        fp_i = 64'h00000003_0000000C;
        tick();
        valid_i = 1'b0;
        samp();
        check("bubble_cnt3",   64'(count_o), 64'd3);
        check("bubble_full_r", 64'(ready_o), 64'd0);
        tick();
        ready_i = 1'b1;
        repeat (4) tick();

        // Flush with three in flight and a beat offered the same cycle.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fp_i = 64'hD0D0D0D0_00000000 + 64'(i); valid_i = 1'b1;
            tick();
        end
        fp_i = 64'hDEADBEEF_0BADF00D; flush_i = 1'b1;
        samp();
        check("flush_pre_cnt", 64'(count_o), 64'd3);
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        samp();
        check("flush_valid", 64'(valid_o), 64'd0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_ready", 64'(ready_o), 64'd1);
        tick();
        ready_i = 1'b1;
        repeat (5) tick();
        fp_i = 64'h12345678_9ABCDEF0; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (4) tick();

        // Reset with a full, stalled pipeline; reset beats valid_i and flush_i.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fp_i = 64'hAAAA0000_5555000 + 64'(i); valid_i = 1'b1;
            tick();
        end
        fp_i = 64'hFFFFFFFF_FFFFFFFF; rst_ni = 1'b0; flush_i = 1'b1;
        tick();
        rst_ni = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        samp();
        check("mrst_valid", 64'(valid_o), 64'd0);
        check("mrst_count", 64'(count_o), 64'd0);
        check("mrst_ready", 64'(ready_o), 64'd1);
        tick();
        fp_i = 64'h7F800000_FF800000; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        samp(); check("post_rst_v1", 64'(valid_o), 64'd0);
        tick(); samp(); check("post_rst_v2", 64'(valid_o), 64'd0);
        tick(); samp();
        check("post_rst_v3", 64'(valid_o), 64'd1);
        check("post_rst_d3", fp_o, 64'h7F800000_FF800000);
        tick(); tick(); tick();

        check("beats_out",  64'(n_out),     64'd15);
        check("sb_empty",   64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
